id_ex_pipe_reg: RTL and testbench

- Pipeline register between decode/forwarding and execute. It captures forwarded operand data (f_reg_ra/rb/rt_data), the immediate and decode control, and presents them to EX as the xREG2_* bus.
- It turns the forwarding unit's do_hazard (load-use) into a one-cycle bubble with a front-end stall.
- It applies branch flushes from EX and holds on a global memory-wait stall, remembering any flush that arrives during the hold.
- It keeps a saturating count of hazard bubbles for performance debug.

---
 rtl/id_ex_pipe_reg.sv | 149 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures forwarded operands and decode controls for EX,
// turns load-use hazards into bubbles, applies branch flushes and holds on memory wait.
module id_ex_pipe_reg #(
   parameter int ALU_OP_W = 5,
   parameter int CNT_W    = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                do_hazard,
   input  logic                do_flush,
   input  logic                do_mem_wait,
   input  logic                id_valid,
   input  logic [31:0]         f_reg_ra_data,
   input  logic [31:0]         f_reg_rb_data,
   input  logic [31:0]         f_reg_rt_data,
   input  logic [31:0]         imm_extend,
   input  logic [ALU_OP_W-1:0] alu_op,
   input  logic                do_dm_read,
   input  logic                do_dm_write,
   input  logic                do_reg_write,
   input  logic [1:0]          select_write_reg,
   input  logic [4:0]          write_reg_addr,
   output logic [31:0]         xREG2_ra_data,
   output logic [31:0]         xREG2_rb_data,
   output logic [31:0]         xREG2_rt_data,
   output logic [31:0]         xREG2_imm_extend,
   output logic [ALU_OP_W-1:0] xREG2_alu_op,
   output logic                xREG2_do_dm_read,
   output logic                xREG2_do_dm_write,
   output logic                xREG2_do_reg_write,
   output logic [1:0]          xREG2_select_write_reg,
   output logic [4:0]          xREG2_write_reg_addr,
   output logic                xREG2_valid,
   output logic                stall_front,
   output logic [CNT_W-1:0]    hazard_cnt
);

   // state        | meaning
   // S_RUN        | normal flow: load, flush bubble or hazard bubble
   // S_HOLD       | memory wait, no flush seen; resumes with RUN rules on release
   // S_HOLD_FLUSH | memory wait with a flush remembered; releases with a bubble
   typedef enum logic [1:0] {S_RUN, S_HOLD, S_HOLD_FLUSH} state_t;

   state_t r_state, w_state_nxt;
   logic   w_load, w_bubble, w_cnt_inc;

   logic [31:0]         r_ra_data, r_rb_data, r_rt_data, r_imm_extend;
   logic [ALU_OP_W-1:0] r_alu_op;
   logic                r_do_dm_read, r_do_dm_write, r_do_reg_write, r_valid;
   logic [1:0]          r_select_write_reg;
   logic [4:0]          r_write_reg_addr;
   logic [CNT_W-1:0]    r_hazard_cnt;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_bubble    = 1'b0;
      w_cnt_inc   = 1'b0;
      case (r_state)
         S_HOLD_FLUSH: begin
            if (!do_mem_wait) begin
               w_bubble    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         default: begin
            if (do_mem_wait) begin
               w_state_nxt = do_flush ? S_HOLD_FLUSH : S_HOLD;
            end else begin
               w_state_nxt = S_RUN;
               if (do_flush) begin
                  w_bubble = 1'b1;
               end else if (do_hazard) begin
                  w_bubble  = 1'b1;
                  w_cnt_inc = 1'b1;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
      endcase
   end

   // HOLD releasing applies RUN rules in the same cycle, so a hazard there must stall too
   assign stall_front = reset &
                        (do_mem_wait | (do_hazard & ~do_flush & (r_state != S_HOLD_FLUSH)));

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state            <= S_RUN;
         r_ra_data          <= '0;
         r_rb_data          <= '0;
         r_rt_data          <= '0;
         r_imm_extend       <= '0;
         r_alu_op           <= '0;
         r_do_dm_read       <= 1'b0;
         r_do_dm_write      <= 1'b0;
         r_do_reg_write     <= 1'b0;
         r_select_write_reg <= '0;
         r_write_reg_addr   <= '0;
         r_valid            <= 1'b0;
         r_hazard_cnt       <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_ra_data          <= f_reg_ra_data;
            r_rb_data          <= f_reg_rb_data;
            r_rt_data          <= f_reg_rt_data;
            r_imm_extend       <= imm_extend;
            r_alu_op           <= alu_op;
            r_do_dm_read       <= do_dm_read;
            r_do_dm_write      <= do_dm_write;
            r_do_reg_write     <= do_reg_write;
            r_select_write_reg <= select_write_reg;
            r_write_reg_addr   <= write_reg_addr;
            r_valid            <= id_valid;
         end else if (w_bubble) begin
            r_ra_data          <= '0;
            r_rb_data          <= '0;
            r_rt_data          <= '0;
            r_imm_extend       <= '0;
            r_alu_op           <= '0;
            r_do_dm_read       <= 1'b0;
            r_do_dm_write      <= 1'b0;
            r_do_reg_write     <= 1'b0;
            r_select_write_reg <= '0;
            r_write_reg_addr   <= '0;
            r_valid            <= 1'b0;
         end
         if (w_cnt_inc && (r_hazard_cnt != {CNT_W{1'b1}})) begin
            r_hazard_cnt <= r_hazard_cnt + CNT_W'(1);
         end
      end
   end

   assign xREG2_ra_data          = r_ra_data;
   assign xREG2_rb_data          = r_rb_data;
   assign xREG2_rt_data          = r_rt_data;
   assign xREG2_imm_extend       = r_imm_extend;
   assign xREG2_alu_op           = r_alu_op;
   assign xREG2_do_dm_read       = r_do_dm_read;
   assign xREG2_do_dm_write      = r_do_dm_write;
   assign xREG2_do_reg_write     = r_do_reg_write;
   assign xREG2_select_write_reg = r_select_write_reg;
   assign xREG2_write_reg_addr   = r_write_reg_addr;
   assign xREG2_valid            = r_valid;
   assign hazard_cnt             = r_hazard_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed scenarios plus random traffic,
// checked against a pending-flush reference model.
module tb_id_ex_pipe_reg;

   localparam int CNT_W = 4;

   typedef struct packed {
      logic        rst;
      logic        hz;
      logic        fl;
      logic        mw;
      logic        vld;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  op;
      logic        rd;
      logic        wr;
      logic        rw;
      logic [1:0]  sel;
      logic [4:0]  addr;
   } in_t;

   typedef struct packed {
      logic        vld;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  op;
      logic        rd;
      logic        wr;
      logic        rw;
      logic [1:0]  sel;
      logic [4:0]  addr;
   } reg_t;

   logic clock = 1'b0;
   logic reset, do_hazard, do_flush, do_mem_wait, id_valid;
   logic [31:0] f_reg_ra_data, f_reg_rb_data, f_reg_rt_data, imm_extend;
   logic [4:0]  alu_op;
   logic        do_dm_read, do_dm_write, do_reg_write;
   logic [1:0]  select_write_reg;
   logic [4:0]  write_reg_addr;
   logic [31:0] xREG2_ra_data, xREG2_rb_data, xREG2_rt_data, xREG2_imm_extend;
   logic [4:0]  xREG2_alu_op;
   logic        xREG2_do_dm_read, xREG2_do_dm_write, xREG2_do_reg_write, xREG2_valid;
   logic [1:0]  xREG2_select_write_reg;
   logic [4:0]  xREG2_write_reg_addr;
   logic        stall_front;
   logic [CNT_W-1:0] hazard_cnt;

   int errors = 0;
   int checks = 0;

   reg_t           q_reg[$];
   logic [CNT_W-1:0] q_cnt[$];
   logic           q_stall[$];

   reg_t             m_out;
   logic [CNT_W-1:0] m_cnt;
   logic             m_pend;

   always #5 clock = ~clock;

   id_ex_pipe_reg #(.ALU_OP_W(5), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .do_hazard(do_hazard), .do_flush(do_flush),
      .do_mem_wait(do_mem_wait), .id_valid(id_valid),
      .f_reg_ra_data(f_reg_ra_data), .f_reg_rb_data(f_reg_rb_data),
      .f_reg_rt_data(f_reg_rt_data), .imm_extend(imm_extend), .alu_op(alu_op),
      .do_dm_read(do_dm_read), .do_dm_write(do_dm_write), .do_reg_write(do_reg_write),
      .select_write_reg(select_write_reg), .write_reg_addr(write_reg_addr),
      .xREG2_ra_data(xREG2_ra_data), .xREG2_rb_data(xREG2_rb_data),
      .xREG2_rt_data(xREG2_rt_data), .xREG2_imm_extend(xREG2_imm_extend),
      .xREG2_alu_op(xREG2_alu_op), .xREG2_do_dm_read(xREG2_do_dm_read),
      .xREG2_do_dm_write(xREG2_do_dm_write), .xREG2_do_reg_write(xREG2_do_reg_write),
      .xREG2_select_write_reg(xREG2_select_write_reg),
      .xREG2_write_reg_addr(xREG2_write_reg_addr), .xREG2_valid(xREG2_valid),
      .stall_front(stall_front), .hazard_cnt(hazard_cnt)
   );

   function automatic in_t rnd_in();
      in_t x;
      x.rst  = 1'b1;
      x.hz   = 1'b0;
      x.fl   = 1'b0;
      x.mw   = 1'b0;
      x.vld  = 1'($urandom);
      x.ra   = $urandom;
      x.rb   = $urandom;
      x.rt   = $urandom;
      x.imm  = $urandom;
      x.op   = 5'($urandom);
      x.rd   = 1'($urandom);
      x.wr   = 1'($urandom);
      x.rw   = 1'($urandom);
      x.sel  = 2'($urandom);
      x.addr = 5'($urandom);
      return x;
   endfunction

   // Drive one cycle of inputs and push what the reference model predicts.
   task automatic step(input in_t x);
      logic exp_stall;
      @(negedge clock);
      reset            = x.rst;
      do_hazard        = x.hz;
      do_flush         = x.fl;
      do_mem_wait      = x.mw;
      id_valid         = x.vld;
      f_reg_ra_data    = x.ra;
      f_reg_rb_data    = x.rb;
      f_reg_rt_data    = x.rt;
      imm_extend       = x.imm;
      alu_op           = x.op;
      do_dm_read       = x.rd;
      do_dm_write      = x.wr;
      do_reg_write     = x.rw;
      select_write_reg = x.sel;
      write_reg_addr   = x.addr;

      exp_stall = x.rst & (x.mw | (x.hz & ~x.fl & ~m_pend));
      if (!x.rst) begin
         m_out  = '0;
         m_cnt  = '0;
         m_pend = 1'b0;
      end else if (x.mw) begin
         m_pend = m_pend | x.fl;
      end else if (m_pend) begin
         m_out  = '0;
         m_pend = 1'b0;
      end else if (x.fl) begin
         m_out = '0;
      end else if (x.hz) begin
         m_out = '0;
         if (m_cnt < CNT_W'(15)) m_cnt = m_cnt + 1'b1;
      end else begin
         m_out = '{vld: x.vld, ra: x.ra, rb: x.rb, rt: x.rt, imm: x.imm, op: x.op,
                   rd: x.rd, wr: x.wr, rw: x.rw, sel: x.sel, addr: x.addr};
      end
      q_stall.push_back(exp_stall);
      q_reg.push_back(m_out);
      q_cnt.push_back(m_cnt);
   endtask

   // Registered outputs settle just after the rising edge.
   initial begin
      reg_t act, exp;
      logic [CNT_W-1:0] ecnt;
      forever begin
         @(posedge clock);
         #1;
         if (q_reg.size() > 0) begin
            exp  = q_reg.pop_front();
            ecnt = q_cnt.pop_front();
            act  = '{vld: xREG2_valid, ra: xREG2_ra_data, rb: xREG2_rb_data,
                     rt: xREG2_rt_data, imm: xREG2_imm_extend, op: xREG2_alu_op,
                     rd: xREG2_do_dm_read, wr: xREG2_do_dm_write, rw: xREG2_do_reg_write,
                     sel: xREG2_select_write_reg, addr: xREG2_write_reg_addr};
            checks++;
            if (act !== exp) begin
               errors++;
               $display("FAIL xreg2_bus @%0t: got %h want %h", $time, act, exp);
            end
            checks++;
            if (hazard_cnt !== ecnt) begin
               errors++;
               $display("FAIL hazard_cnt @%0t: got %0d want %0d", $time, hazard_cnt, ecnt);
            end
         end
      end
   end

   // stall_front is combinational; sample it once the new inputs have settled.
   initial begin
      logic es;
      forever begin
         @(negedge clock);
         #2;
         if (q_stall.size() > 0) begin
            es = q_stall.pop_front();
            checks++;
            if (stall_front !== es) begin
               errors++;
               $display("FAIL stall_front @%0t: got %b want %b", $time, stall_front, es);
            end
         end
      end
   end

   initial begin
      in_t x;
      m_out  = '0;
      m_cnt  = '0;
      m_pend = 1'b0;
      reset = 1'b0; do_hazard = 1'b0; do_flush = 1'b0; do_mem_wait = 1'b0;
      id_valid = 1'b0; f_reg_ra_data = '0; f_reg_rb_data = '0; f_reg_rt_data = '0;
      imm_extend = '0; alu_op = '0; do_dm_read = 1'b0; do_dm_write = 1'b0;
      do_reg_write = 1'b0; select_write_reg = '0; write_reg_addr = '0;

      // reset with every input nonzero
      repeat (2) begin
         x = '{rst: 1'b0, hz: 1'b1, fl: 1'b1, mw: 1'b1, vld: 1'b1, ra: 32'hFFFF_FFFF,
               rb: 32'h1111_1111, rt: 32'h2222_2222, imm: 32'h3333_3333, op: 5'h1F,
               rd: 1'b1, wr: 1'b1, rw: 1'b1, sel: 2'b11, addr: 5'h1F};
         step(x);
      end
      x = '0; x.rst = 1'b1; x.vld = 1'b1; x.op = 5'd3; x.addr = 5'd7;
      step(x);

      // load-use: one bubble, then the held instruction loads
      x = '0; x.rst = 1'b1; x.vld = 1'b1; x.rw = 1'b1; x.ra = 32'h1234; x.hz = 1'b1;
      step(x);
      x.hz = 1'b0;
      step(x);

      // flush beats hazard
      x = rnd_in(); x.hz = 1'b1; x.fl = 1'b1;
      step(x);
      x = rnd_in();
      step(x);

      // memory hold, then load on release
      repeat (3) begin
         x = rnd_in(); x.mw = 1'b1;
         step(x);
      end
      x = rnd_in();
      step(x);

      // flush during hold
      x = rnd_in(); x.mw = 1'b1;
      step(x);
      x = rnd_in(); x.mw = 1'b1; x.fl = 1'b1;
      step(x);
      x = rnd_in(); x.mw = 1'b1;
      step(x);
      x = rnd_in(); x.hz = 1'b1;
      step(x);
      repeat (2) begin
         x = rnd_in();
         step(x);
      end

      // random traffic
      repeat (400) begin
         x = rnd_in();
         x.rst = ($urandom_range(0, 49) != 0);
         x.hz  = ($urandom_range(0, 3) == 0);
         x.fl  = ($urandom_range(0, 5) == 0);
         x.mw  = ($urandom_range(0, 3) == 0);
         step(x);
      end

      // saturation: 20 separated hazards after a clean reset
      x = rnd_in(); x.rst = 1'b0;
      step(x);
      repeat (20) begin
         x = rnd_in(); x.hz = 1'b1;
         step(x);
         x = rnd_in();
         step(x);
      end
      repeat (3) begin
         x = rnd_in();
         step(x);
      end

      repeat (3) @(posedge clock);
      #3;
      checks++;
      if (q_reg.size() != 0 || q_stall.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d entries left want 0/0", q_reg.size(), q_stall.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
